// File: rtl/fsm_pkg.sv
// Shared constants for the fsm library: output-mode and overlap selectors
// plus the classic 1001 pattern used as the default target.
package fsm_pkg;

  localparam logic MODE_MEALY = 1'b0;
  localparam logic MODE_MOORE = 1'b1;

  localparam logic OVL_OFF = 1'b0;
  localparam logic OVL_ON  = 1'b1;

  localparam logic [3:0] PAT_1001 = 4'b1001;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; sat mirrors &cnt and is
// registered together with the count so both change on the same edge.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         sat
);

  logic [W-1:0] cnt_next;

  always_comb begin
    cnt_next = cnt;
    if (clr) begin
      cnt_next = '0;
    end else if (inc && !(&cnt)) begin
      cnt_next = cnt + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      sat <= 1'b0;
    end else begin
      cnt <= cnt_next;
      sat <= &cnt_next;
    end
  end

endmodule

// File: rtl/seq_detect_param.sv
// Serial pattern detector with runtime pattern, overlap and Mealy/Moore
// selection; the fill count keeps reset-zero history from ever matching.
module seq_detect_param
  import fsm_pkg::*;
#(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             n,
  input  logic             clr,
  input  logic [PAT_W-1:0] pattern,
  input  logic             ovl,
  input  logic             moore,
  output logic             d,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);

  localparam int                FILL_W   = $clog2(PAT_W);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

  logic [PAT_W-2:0]  hist;
  logic [PAT_W-2:0]  hist_next;
  logic [FILL_W-1:0] fill;
  logic [FILL_W-1:0] fill_next;
  logic [PAT_W-1:0]  window;
  logic              hit;
  logic              d_q;

  assign window = {hist, n};
  assign hit    = en & ~clr & (fill == FILL_MAX) & (window == pattern);

  // A non-overlapping match restarts from an empty history.
  always_comb begin
    hist_next = hist;
    fill_next = fill;
    if (clr) begin
      hist_next = '0;
      fill_next = '0;
    end else if (en) begin
      if (hit && (ovl == OVL_OFF)) begin
        hist_next = '0;
        fill_next = '0;
      end else begin
        hist_next = window[PAT_W-2:0];
        fill_next = (fill == FILL_MAX) ? fill : fill + FILL_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist <= '0;
      fill <= '0;
      d_q  <= 1'b0;
    end else begin
      hist <= hist_next;
      fill <= fill_next;
      d_q  <= hit;
    end
  end

  assign d = rst & ((moore == MODE_MOORE) ? d_q : hit);

  sat_counter #(
    .W(CNT_W)
  ) u_cnt (
    .clk(clk),
    .rst(rst),
    .clr(clr),
    .inc(hit),
    .cnt(match_cnt),
    .sat(cnt_sat)
  );

endmodule
